// File: rtl/noc_input_buffer_pkg.sv
// noc_input_buffer_pkg: shared link-buffer constants and credit FSM state encodings.
package noc_input_buffer_pkg;
    localparam int NOC_DATA_WIDTH  = 32;
    localparam int NOC_INBUF_DEPTH = 8;
    localparam logic [0:0] NOC_CR_INIT = 1'b0;
    localparam logic [0:0] NOC_CR_RUN  = 1'b1;
endpackage

// File: rtl/noc_input_buffer_if.sv
// noc_input_buffer_if: link-side and consumer-side handshake bundle of the receive buffer.
interface noc_input_buffer_if
    import noc_input_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = NOC_DATA_WIDTH
);
    logic [DATA_WIDTH-1:0] link_data;
    logic                  link_valid;
    logic                  link_ready;
    logic                  credit_out;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;

    modport slave (
        input  link_data, link_valid, out_ready,
        output link_ready, credit_out, out_data, out_valid
    );
    modport master (
        output link_data, link_valid, out_ready,
        input  link_ready, credit_out, out_data, out_valid
    );
endinterface

// File: rtl/noc_input_buffer_credit_gen.sv
// noc_credit_gen: issues DEPTH initial credits after reset, then one registered credit per pop.
module noc_credit_gen
    import noc_input_buffer_pkg::*;
#(
    parameter int DEPTH = NOC_INBUF_DEPTH
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pop,
    output logic credit_out
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [0:0]       state;
    logic [CNT_W-1:0] init_cnt;
    logic [CNT_W-1:0] credit_pend;
    logic [CNT_W-1:0] pend_sum;
    logic             credit_next;

    // Pops seen during INIT are parked in credit_pend and drained once RUN starts.
    always_comb begin
        pend_sum    = credit_pend + CNT_W'(pop);
        credit_next = (state == NOC_CR_INIT) || (pend_sum != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= NOC_CR_INIT;
            init_cnt    <= '0;
            credit_pend <= '0;
            credit_out  <= 1'b0;
        end else begin
            credit_out <= credit_next;
            if (state == NOC_CR_INIT) begin
                init_cnt    <= init_cnt + 1'b1;
                credit_pend <= pend_sum;
                if (init_cnt == CNT_W'(DEPTH - 1))
                    state <= NOC_CR_RUN;
            end else begin
                credit_pend <= pend_sum - CNT_W'(credit_next);
            end
        end
    end
endmodule

// File: rtl/noc_input_buffer.sv
// noc_input_buffer: credit-returning receive FIFO with FWFT output.
// Optional sticky overflow detection under macro NOC_INBUF_OVF_CHECK_EN.
module noc_input_buffer
    import noc_input_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = NOC_DATA_WIDTH,
    parameter int DEPTH      = NOC_INBUF_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    noc_input_buffer_if.slave          bus,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic                       ovf_err
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic                  push;
    logic                  pop;

    assign bus.link_ready = occupancy != CNT_W'(DEPTH);
    assign bus.out_valid  = occupancy != '0;
    assign bus.out_data   = bus.out_valid ? mem[rd_ptr] : '0;
    assign push           = bus.link_valid & bus.link_ready;
    assign pop            = bus.out_valid & bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            occupancy <= occupancy + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= bus.link_data;
    end

    noc_credit_gen #(.DEPTH(DEPTH)) u_credit_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .pop        (pop),
        .credit_out (bus.credit_out)
    );

`ifdef NOC_INBUF_OVF_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ovf_err <= 1'b0;
        else if (bus.link_valid && !bus.link_ready)
            ovf_err <= 1'b1;
    end
`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst_n && bus.link_valid && !bus.link_ready)
            $error("noc_input_buffer: flit offered while full, dropped");
    end
`endif
`else
    assign ovf_err = 1'b0;
`endif
endmodule
